unified_mem_arbiter: RTL and testbench



---
 rtl/arb_pkg.sv | 31 +++
 rtl/unified_mem_arbiter_sat_counter.sv | 24 ++
 rtl/unified_mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and grant encoding for the unified memory arbiter.
package arb_pkg;

    // Arbiter sequencing: one access in flight from grant to acknowledge.
    typedef enum logic [2:0] {
        IDLE,
        ISSUE_IF,
        ISSUE_DM,
        WAIT_IF,
        WAIT_DM,
        RESP
    } arb_state_e;

    // Grant encoding, also used as the stored last-grant value.
    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_DM = 1'b1;

    // Pick the requester to serve; on a conflict the one not served last wins.
    function automatic logic pick_grant(input logic if_req,
                                        input logic dm_req,
                                        input logic last_grant);
        if (if_req && dm_req) begin
            return ~last_grant;
        end
        if (dm_req) begin
            return GNT_DM;
        end
        return GNT_IF;
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Increment on enable unless already at the maximum value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port unified memory between instruction fetch (IF)
// and the data stage (DM). One access is in flight at a time; the requester
// gets a one-cycle ack with read data, and stalls while it waits.
module unified_mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic              stall_if,
    output logic              stall_mem,
    output logic [CNT_W-1:0]  conflict_cnt
);

    arb_state_e        r_state;
    arb_state_e        w_next_state;
    logic              r_last_grant;
    logic              w_take;
    logic              w_grant;
    logic              w_conflict;

    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_if_ack;
    logic              r_dm_ack;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;

    // State register; reset aborts any access in flight.
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and grant decision; requests are only looked at in IDLE.
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_take       = 1'b0;
        w_conflict   = 1'b0;
        w_grant      = r_last_grant;
        case (r_state)
            IDLE: begin
                if (if_req || dm_req) begin
                    w_take       = 1'b1;
                    w_conflict   = if_req && dm_req;
                    w_grant      = pick_grant(if_req, dm_req, r_last_grant);
                    w_next_state = (w_grant == GNT_DM) ? ISSUE_DM : ISSUE_IF;
                end
            end
            ISSUE_IF: w_next_state = WAIT_IF;
            ISSUE_DM: w_next_state = WAIT_DM;
            WAIT_IF:  if (mem_valid) w_next_state = RESP;
            WAIT_DM:  if (mem_valid) w_next_state = RESP;
            RESP:     w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    // Round-robin memory: only a conflict decides who goes next time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= GNT_DM;
        end else if (w_conflict) begin
            r_last_grant <= w_grant;
        end
    end

    // Latch the granted command; mem_en is high only in the ISSUE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_en <= w_take;
            if (w_take) begin
                if (w_grant == GNT_DM) begin
                    r_mem_we    <= dm_we;
                    r_mem_addr  <= dm_addr;
                    r_mem_wdata <= dm_wdata;
                end else begin
                    r_mem_we    <= 1'b0;
                    r_mem_addr  <= if_addr;
                    r_mem_wdata <= '0;
                end
            end
        end
    end

    // Capture completion data; ack only a requester that is still waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_ack   <= 1'b0;
            r_dm_ack   <= 1'b0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            r_if_ack <= 1'b0;
            r_dm_ack <= 1'b0;
            if ((r_state == WAIT_IF) && mem_valid) begin
                r_if_rdata <= mem_rdata;
                r_if_ack   <= if_req;
            end
            if ((r_state == WAIT_DM) && mem_valid) begin
                r_dm_rdata <= mem_rdata;
                r_dm_ack   <= dm_req;
            end
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_conflict_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_inc  (w_conflict),
        .o_count(conflict_cnt)
    );

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_ack    = r_if_ack;
    assign dm_ack    = r_dm_ack;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign stall_if  = if_req & ~r_if_ack;
    assign stall_mem = dm_req & ~r_dm_ack;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios followed by
// random request mixes, checked against a transaction-level reference model
// and a behavioural memory with programmable latency.
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [63:0] if_addr;
    logic [63:0] if_rdata;
    logic        if_ack;
    logic        dm_req;
    logic        dm_we;
    logic [63:0] dm_addr;
    logic [63:0] dm_wdata;
    logic [63:0] dm_rdata;
    logic        dm_ack;
    logic        mem_en;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_valid;
    logic        stall_if;
    logic        stall_mem;
    logic [15:0] conflict_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model state
    bit          last_dm;
    int          exp_cnt;
    logic [63:0] ref_mem [logic [63:0]];

    // Behavioural memory state
    logic [63:0] hw_mem [logic [63:0]];
    int          mem_lat;
    int          pend;
    bit          spurious;
    logic [63:0] cmd_addr;

    unified_mem_arbiter #(
        .ADDR_W(64),
        .DATA_W(64),
        .CNT_W (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_ack      (if_ack),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_rdata    (dm_rdata),
        .dm_ack      (dm_ack),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_valid   (mem_valid),
        .stall_if    (stall_if),
        .stall_mem   (stall_mem),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] dflt(input logic [63:0] a);
        return {a[31:0] ^ 32'hA5A5_0000, ~a[31:0]};
    endfunction

    function automatic logic [63:0] ref_rd(input logic [63:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic [63:0] hw_rd(input logic [63:0] a);
        return hw_mem.exists(a) ? hw_mem[a] : dflt(a);
    endfunction

    function automatic logic [63:0] pool_addr();
        logic [63:0] a;
        a = 64'($urandom_range(0, 15)) << 3;
        return a;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Per-cycle control outputs against expectation.
    task automatic check_cycle(input string tag, input bit e_en, input bit e_if_ack, input bit e_dm_ack);
        check({tag, " mem_en"}, 64'(mem_en), 64'(e_en));
        check({tag, " if_ack"}, 64'(if_ack), 64'(e_if_ack));
        check({tag, " dm_ack"}, 64'(dm_ack), 64'(e_dm_ack));
        check({tag, " stall_if"}, 64'(stall_if), 64'(if_req && !e_if_ack));
        check({tag, " stall_mem"}, 64'(stall_mem), 64'(dm_req && !e_dm_ack));
        check({tag, " conflict_cnt"}, 64'(conflict_cnt), 64'(exp_cnt));
    endtask

    task automatic check_zero(input string tag);
        check({tag, " mem_en"}, 64'(mem_en), 64'd0);
        check({tag, " mem_we"}, 64'(mem_we), 64'd0);
        check({tag, " mem_addr"}, mem_addr, 64'd0);
        check({tag, " mem_wdata"}, mem_wdata, 64'd0);
        check({tag, " if_ack"}, 64'(if_ack), 64'd0);
        check({tag, " dm_ack"}, 64'(dm_ack), 64'd0);
        check({tag, " if_rdata"}, if_rdata, 64'd0);
        check({tag, " dm_rdata"}, dm_rdata, 64'd0);
        check({tag, " conflict_cnt"}, 64'(conflict_cnt), 64'd0);
    endtask

    // One arbitration round, entered in an IDLE cycle. Adds new requests
    // (a side already waiting keeps its request), predicts the winner from
    // the round-robin rule and checks the whole access cycle by cycle.
    task automatic round(input string tag,
                         input bit add_if, input logic [63:0] a_if,
                         input bit add_dm, input bit we,
                         input logic [63:0] a_dm, input logic [63:0] wd,
                         input int lat, input bit drop);
        bit          win_dm;
        bit          conflict;
        bit          ack;
        bit          e_we;
        logic [63:0] e_addr;
        logic [63:0] e_wdata;
        logic [63:0] e_rdata;
        if (add_if && !if_req) begin
            if_req  = 1'b1;
            if_addr = a_if;
        end
        if (add_dm && !dm_req) begin
            dm_req   = 1'b1;
            dm_we    = we;
            dm_addr  = a_dm;
            dm_wdata = wd;
        end
        mem_lat = lat;
        if (!if_req && !dm_req) begin
            // Nothing to serve: a stray mem_valid must not produce an ack.
            spurious = 1'b1;
            #1;
            check_cycle({tag, " idle"}, 1'b0, 1'b0, 1'b0);
            @(negedge clk); #2;
            check_cycle({tag, " idle+1"}, 1'b0, 1'b0, 1'b0);
            return;
        end
        conflict = if_req && dm_req;
        win_dm   = conflict ? !last_dm : dm_req;
        #1;
        check_cycle({tag, " c0"}, 1'b0, 1'b0, 1'b0);
        if (conflict) begin
            last_dm = win_dm;
            if (exp_cnt != 65535) exp_cnt++;
        end
        e_addr  = win_dm ? dm_addr : if_addr;
        e_we    = win_dm && dm_we;
        e_wdata = dm_wdata;
        e_rdata = ref_rd(e_addr);
        if (e_we) ref_mem[e_addr] = e_wdata;
        for (int c = 1; c <= 2 + lat; c++) begin
            @(negedge clk); #2;
            ack = (c == 2 + lat) && !drop;
            check_cycle({tag, $sformatf(" c%0d", c)}, c == 1, ack && !win_dm, ack && win_dm);
            if (c == 1) begin
                check({tag, " mem_addr"}, mem_addr, e_addr);
                check({tag, " mem_we"}, 64'(mem_we), 64'(e_we));
                if (e_we) check({tag, " mem_wdata"}, mem_wdata, e_wdata);
            end
            if (c == 2 && drop) begin
                if (win_dm) dm_req = 1'b0;
                else        if_req = 1'b0;
            end
        end
        if (!drop) begin
            if (!win_dm)     check({tag, " if_rdata"}, if_rdata, e_rdata);
            else if (!e_we)  check({tag, " dm_rdata"}, dm_rdata, e_rdata);
            if (win_dm) dm_req = 1'b0;
            else        if_req = 1'b0;
        end
        // Cycle after RESP is IDLE again; nothing may be issued or acked.
        @(negedge clk); #2;
        check_cycle({tag, " post"}, 1'b0, 1'b0, 1'b0);
    endtask

    // Behavioural memory: responds mem_lat cycles after a command strobe.
    initial begin
        mem_valid = 1'b0;
        mem_rdata = '0;
        pend      = 0;
        cmd_addr  = '0;
        forever begin
            @(negedge clk);
            mem_valid = 1'b0;
            if (spurious) begin
                spurious  = 1'b0;
                mem_valid = 1'b1;
                mem_rdata = {$urandom, $urandom};
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mem_valid = 1'b1;
                    mem_rdata = hw_rd(cmd_addr);
                end
            end
            if (mem_en && pend == 0) begin
                cmd_addr = mem_addr;
                pend     = mem_lat;
                if (mem_we) hw_mem[mem_addr] = mem_wdata;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        if_req   = 1'b0;
        if_addr  = '0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        spurious = 1'b0;
        mem_lat  = 1;
        last_dm  = 1'b1;
        exp_cnt  = 0;
        ref_mem[64'h40] = 64'hF840_0001;
        hw_mem[64'h40]  = 64'hF840_0001;

        // 1. Reset state
        #12;
        check_zero("reset");
        check("reset stall_if", 64'(stall_if), 64'd0);
        check("reset stall_mem", 64'(stall_mem), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        check_cycle("rst_idle", 1'b0, 1'b0, 1'b0);
        repeat (2) begin
            @(negedge clk); #2;
            check_cycle("rst_idle", 1'b0, 1'b0, 1'b0);
        end

        // 2. Minimum-latency fetch
        round("fetch40", 1'b1, 64'h40, 1'b0, 1'b0, '0, '0, 1, 1'b0);
        // 3. Store, then read it back with a slower memory
        round("store100", 1'b0, '0, 1'b1, 1'b1, 64'h100, 64'hDEAD, 1, 1'b0);
        round("load100", 1'b0, '0, 1'b1, 1'b0, 64'h100, '0, 2, 1'b0);
        // 4. Conflicts: IF first after reset, then alternating
        round("conf1", 1'b1, 64'h48, 1'b1, 1'b0, 64'h50, '0, 1, 1'b0);
        round("conf2", 1'b1, 64'h58, 1'b0, 1'b0, '0, '0, 1, 1'b0);
        round("conf3", 1'b0, '0, 1'b1, 1'b1, 64'h60, 64'h1234, 2, 1'b0);
        round("drain", 1'b0, '0, 1'b0, 1'b0, '0, '0, 1, 1'b0);
        // 5. Store flushed during WAIT still writes memory
        round("flush", 1'b0, '0, 1'b1, 1'b1, 64'h68, 64'hCAFE_F00D, 2, 1'b1);
        round("load68", 1'b0, '0, 1'b1, 1'b0, 64'h68, '0, 1, 1'b0);

        // 6. Reset during WAIT_IF; the late mem_valid arrives after release
        if_req  = 1'b1;
        if_addr = 64'h80;
        mem_lat = 5;
        @(negedge clk); #2;
        check("rstwait mem_en", 64'(mem_en), 64'd1);
        @(negedge clk); #2;
        rst_n  = 1'b0;
        if_req = 1'b0;
        #1;
        check_zero("rstwait");
        last_dm = 1'b1;
        exp_cnt = 0;
        @(negedge clk); #2;
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk); #2;
            check_cycle("post_rst", 1'b0, 1'b0, 1'b0);
        end
        round("post_rst_conf", 1'b1, 64'h18, 1'b1, 1'b0, 64'h20, '0, 1, 1'b0);

        // Random mixes of requests, latencies and flushes
        for (int i = 0; i < 150; i++) begin
            round("rand",
                  $urandom_range(0, 2) != 0, pool_addr(),
                  $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                  pool_addr(), {$urandom, $urandom},
                  int'($urandom_range(1, 3)), $urandom_range(0, 9) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
